// File: rtl/uart_frame_deframer.sv
// Sync-hunting, length-prefixed frame deframer packing UART bytes into words.
// Optional inter-byte timeout enabled by defining UART_DEFRAMER_TIMEOUT_EN.
module uart_frame_deframer #(
    parameter int unsigned WORD_BYTES     = 4,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic [WORD_BYTES-1:0]   out_keep,
    output logic                    out_last,
    output logic                    frame_done,
    output logic                    frame_err,
    output logic [2:0]              err_code,
    output logic                    busy
);

    localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = 8 * WORD_BYTES;

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK} state_t;

    state_t                state;
    logic [7:0]            remaining;
    logic [7:0]            csum;
    logic [LW-1:0]         lane_idx;
    logic [DW-1:0]         pack;
    logic [WORD_BYTES-1:0] pack_keep;
    logic                  ovf;

    logic [DW-1:0]         mem_data [FIFO_DEPTH];
    logic [WORD_BYTES-1:0] mem_keep [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;

    logic [DW-1:0]         push_data;
    logic [WORD_BYTES-1:0] push_keep;
    logic                  push_last;
    logic                  push;
    logic                  push_ok;
    logic                  pop;
    logic                  full;

    // Merge the incoming byte into the pack word and decide whether it completes
    always_comb begin
        push_data = pack | (DW'(rx_data) << {lane_idx, 3'b000});
        push_keep = pack_keep | (WORD_BYTES'(1) << lane_idx);
        push_last = (remaining == 8'd1);
        push      = (state == S_PAYLOAD) && rx_valid &&
                    ((lane_idx == LW'(WORD_BYTES - 1)) || push_last);
    end

    assign full      = (wr_ptr[PW] != rd_ptr[PW]) &&
                       (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign out_valid = (wr_ptr != rd_ptr);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && (!full || pop);
    assign busy      = (state != S_IDLE);

    assign out_data = out_valid ? mem_data[rd_ptr[PW-1:0]] : '0;
    assign out_keep = out_valid ? mem_keep[rd_ptr[PW-1:0]] : '0;
    assign out_last = out_valid ? mem_last[rd_ptr[PW-1:0]] : 1'b0;

    // Word storage; contents are only visible while the entry is occupied
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr[PW-1:0]] <= push_data;
            mem_keep[wr_ptr[PW-1:0]] <= push_keep;
            mem_last[wr_ptr[PW-1:0]] <= push_last;
        end
    end

    // FIFO pointers with wrap bit for full/empty distinction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

`ifdef UART_DEFRAMER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_cnt;
    logic          timeout_hit;

    assign timeout_hit = (state != S_IDLE) &&
                         (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Inter-byte idle counter, only running mid-frame
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            idle_cnt <= '0;
        else if (rx_valid || state == S_IDLE)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + CW'(1);
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    // Frame parser: sync hunt, length, payload packing, checksum verdict
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            remaining  <= '0;
            csum       <= '0;
            lane_idx   <= '0;
            pack       <= '0;
            pack_keep  <= '0;
            ovf        <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 3'd0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (push && full && !pop)
                ovf <= 1'b1;
            if (rx_valid) begin
                unique case (state)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state     <= S_LEN;
                            ovf       <= 1'b0;
                            lane_idx  <= '0;
                            pack      <= '0;
                            pack_keep <= '0;
                        end
                    end
                    S_LEN: begin
                        if (rx_data == 8'd0) begin
                            state     <= S_IDLE;
                            frame_err <= 1'b1;
                            err_code  <= 3'd1;
                        end else begin
                            remaining <= rx_data;
                            csum      <= rx_data;
                            state     <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        csum      <= csum ^ rx_data;
                        remaining <= remaining - 8'd1;
                        if (push) begin
                            pack      <= '0;
                            pack_keep <= '0;
                            lane_idx  <= '0;
                        end else begin
                            pack      <= push_data;
                            pack_keep <= push_keep;
                            lane_idx  <= lane_idx + LW'(1);
                        end
                        if (push_last)
                            state <= S_CHECK;
                    end
                    S_CHECK: begin
                        state <= S_IDLE;
                        if (ovf) begin
                            frame_err <= 1'b1;
                            err_code  <= 3'd3;
                        end else if (rx_data != csum) begin
                            frame_err <= 1'b1;
                            err_code  <= 3'd2;
                        end else begin
                            frame_done <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
`ifdef UART_DEFRAMER_TIMEOUT_EN
            else if (timeout_hit) begin
                state     <= S_IDLE;
                lane_idx  <= '0;
                pack      <= '0;
                pack_keep <= '0;
                frame_err <= 1'b1;
                err_code  <= 3'd4;
            end
`endif
        end
    end

endmodule

// File: doc/uart_frame_deframer.md
# uart_frame_deframer

Byte-to-word deframer sitting directly downstream of the UART receiver in the host link. Consumes the receiver's one-cycle `valid`/`data` byte strobes, hunts for a sync byte, parses a length-prefixed frame with an XOR checksum, and packs payload bytes little-endian into words. Words are buffered in a small FIFO and handed to the command/hash datapath over a valid/ready handshake.

## Interface
- `WORD_BYTES`, 4, bytes per output word (1..8)
- `FIFO_DEPTH`, 8, output word FIFO entries (power of two, ≥2)
- `SYNC_BYTE`, 8'hA5, frame start marker
- `TIMEOUT_CYCLES`, 50000, inter-byte timeout in clocks (used only with `UART_DEFRAMER_TIMEOUT_EN`)

- `clk`  in  1  system clock; single clock domain
- `resetn`  in  1  asynchronous, active-low reset
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte
- `rx_data`  in  8  received byte
- `out_valid`  out  1  FIFO head word available
- `out_ready`  in  1  consumer accepts head word
- `out_data`  out  8*WORD_BYTES  payload word, byte 0 in bits [7:0]
- `out_keep`  out  WORD_BYTES  valid-byte mask for `out_data`
- `out_last`  out  1  word is the final word of its frame
- `frame_done`  out  1  one-cycle pulse: frame ended with no error
- `frame_err`  out  1  one-cycle pulse: frame ended or aborted with error
- `err_code`  out  3  code of the most recent error; held until the next error
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- Frame format: `SYNC_BYTE`, `LEN` (1..255 payload bytes), `LEN` payload bytes, `CSUM` = XOR of `LEN` and all payload bytes.
- FSM states: IDLE, LEN, PAYLOAD, CHECK. State changes only on `rx_valid`, except timeout.
  - IDLE: byte == `SYNC_BYTE` → LEN; any other byte is discarded silently.
  - LEN: byte == 0 → `frame_err`, code 1 (LEN_ZERO), → IDLE. Otherwise load `remaining` = byte and `csum` = byte, then → PAYLOAD.
  - PAYLOAD: write the byte into lane `lane_idx` of the pack register, `csum ^= byte`, decrement `remaining`. Push the word when `lane_idx == WORD_BYTES-1` or `remaining == 1`. On push: `keep` = lanes written, unwritten lanes are zero, `last` = (`remaining == 1`), `lane_idx` clears. Last byte → CHECK.
  - CHECK: byte ≠ `csum` → code 2 (CSUM). Then → IDLE and pulse the result.
- Overflow: a push while the FIFO is full and not popping in the same cycle drops that word and sets a sticky per-frame overflow flag. At CHECK, overflow reports code 3 (OVERFLOW) and takes priority over CSUM.
- Error codes: 0 none, 1 LEN_ZERO, 2 CSUM, 3 OVERFLOW, 4 TIMEOUT. `frame_done` never leaves `err_code` changed.
- Words already pushed are never retracted on an error. The consumer discards the frame on `frame_err`.
- `LEN` is 8 bit, so `remaining` is 8 bit and `lane_idx` is `$clog2(WORD_BYTES)` bits (minimum 1). FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits with wrap bit for full/empty.

## Timing
- All outputs are 0 during and after reset: `out_valid`, `out_data`, `out_keep`, `out_last`, `frame_done`, `frame_err`, `err_code`, `busy`. Reset also empties the FIFO, sets state to IDLE, and clears the pack register and flags. Reset mid-frame discards everything immediately.
- A byte is consumed on the edge where `rx_valid` = 1. There is no input backpressure.
- Push is registered on the edge of the completing byte. `out_valid` rises on the following cycle (first-word latency: 1 clock after the byte's `rx_valid` edge).
- Pop occurs on an edge where `out_valid && out_ready`. `out_*` is stable while `out_valid && !out_ready`.
- Push and pop in the same cycle while full: both occur, and the word is not dropped.
- `frame_done`/`frame_err` pulse for exactly one cycle, in the cycle after the CHECK or LEN byte edge. `err_code` updates on the same edge as the pulse.
- Sustained rate: one byte per clock accepted with no loss, provided the FIFO is not full.

## Configuration
- `UART_DEFRAMER_TIMEOUT_EN` defined:
  - An idle counter runs in any state ≠ IDLE and clears on every `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`: → IDLE, the partial pack word is discarded, `frame_err` pulses with code 4, and `busy` drops on the same edge.
  - An `rx_valid` in the terminal cycle wins: the byte is consumed and no timeout occurs.
- Not defined: no counter, and the FSM waits indefinitely. Code 4 is never produced.

## Test plan
- Good frame (`WORD_BYTES`=4, `out_ready`=1): bytes 00 FF A5 05 11 22 33 44 55 14. Expect:
  - word 0x44332211, keep 1111, last 0;
  - word 0x00000055, keep 0001, last 1;
  - one `frame_done`, `err_code` 0, `busy` low after the final byte.
- Bad checksum: same frame ending in 15. Expect the same two words, then `frame_err` with `err_code` 2.
- Zero length: A5 00. Expect `frame_err` code 1 one cycle after the 00 byte, no words, `busy` low. A following good frame is decoded normally.
- Overflow: `out_ready`=0, `LEN`=40 with correct `CSUM`. Expect exactly 8 words held, then `frame_err` code 3 at CHECK. Releasing `out_ready` drains exactly 8 words.
- Timeout (macro on, `TIMEOUT_CYCLES`=100): A5 03 11, then idle. Expect `frame_err` code 4 exactly 100 cycles after the 11 byte, no word output, `busy` low. With the macro off, `busy` stays high.
- Reset mid-payload: assert `resetn`=0 after A5 08 11 22 33 44 55. Expect all outputs 0 asynchronously and FIFO empty. After release, a good frame decodes correctly.
